// File: rtl/stack_queue_alu.sv
// Stack/queue buffer with add/sub/pop/clear commands over a single-port synchronous-read RAM.
// Define STACK_QUEUE_ALU_SAT_EN to saturate arithmetic results on carry/borrow instead of wrapping.
module stack_queue_alu #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stack_queue,
    input  logic [WIDTH-1:0] din,
    input  logic             push,
    input  logic             pop,
    input  logic             op_add,
    input  logic             op_sub,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             busy,
    output logic             err,
    output logic             ovf
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [2:0] {StIdle, StRdA, StRdB, StExec, StWr} state_e;
    typedef enum logic [1:0] {OpPop, OpAdd, OpSub} op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
    logic             ovf_q, ovf_d, err_q, err_d, mode_q, mode_d;
    logic             mode_eff;
    logic [WIDTH:0]   sum;
    logic [AW-1:0]    top_addr, second_addr;

    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata, rdata_q;
    logic [WIDTH-1:0] mem [DEPTH];

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Mode follows the request only while the buffer is empty, so a push in that cycle
    // already uses the new mode.
    assign mode_eff    = (state_q == StIdle && count_q == '0) ? stack_queue : mode_q;
    assign top_addr    = AW'(count_q - 1'b1);
    assign second_addr = AW'(count_q - CNT_W'(2));
    assign sum         = (op_q == OpSub) ? ({1'b0, y_q} - {1'b0, x_q})
                                         : ({1'b0, y_q} + {1'b0, x_q});

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        count_d   = count_q;
        head_d    = head_q;
        tail_d    = tail_q;
        dout_d    = dout_q;
        x_d       = x_q;
        y_d       = y_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        err_d     = 1'b0;
        mode_d    = mode_eff;
        mem_we    = 1'b0;
        mem_addr  = head_q;
        mem_wdata = din;
        unique case (state_q)
            StIdle: begin
                if (clear) begin
                    count_d = '0;
                    head_d  = '0;
                    tail_d  = '0;
                    ovf_d   = 1'b0;
                    dout_d  = '0;
                end else if (push) begin
                    if (count_q == DEPTH_C) begin
                        err_d = 1'b1;
                    end else begin
                        mem_we   = 1'b1;
                        mem_addr = mode_eff ? tail_q : AW'(count_q);
                        tail_d   = mode_eff ? wrap_inc(tail_q) : tail_q;
                        count_d  = count_q + 1'b1;
                        dout_d   = din;
                    end
                end else if (pop) begin
                    if (count_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        mem_addr = mode_eff ? head_q : top_addr;
                        op_d     = OpPop;
                        state_d  = StRdA;
                    end
                end else if (op_add || op_sub) begin
                    if (count_q < CNT_W'(2)) begin
                        err_d = 1'b1;
                    end else begin
                        mem_addr = mode_eff ? head_q : top_addr;
                        op_d     = op_add ? OpAdd : OpSub;
                        state_d  = StRdA;
                    end
                end
            end
            StRdA: begin
                if (op_q == OpPop) begin
                    dout_d  = rdata_q;
                    count_d = count_q - 1'b1;
                    head_d  = mode_q ? wrap_inc(head_q) : head_q;
                    state_d = StIdle;
                end else begin
                    x_d      = rdata_q;
                    mem_addr = mode_q ? wrap_inc(head_q) : second_addr;
                    state_d  = StRdB;
                end
            end
            StRdB: begin
                y_d     = rdata_q;
                state_d = StExec;
            end
            StExec: begin
                if (sum[WIDTH]) begin
                    ovf_d = 1'b1;
                end
`ifdef STACK_QUEUE_ALU_SAT_EN
                if (sum[WIDTH]) begin
                    res_d = (op_q == OpSub) ? '0 : '1;
                end else begin
                    res_d = sum[WIDTH-1:0];
                end
`else
                res_d = sum[WIDTH-1:0];
`endif
                state_d = StWr;
            end
            StWr: begin
                // Stack result lands where Y was; queue result is enqueued at the tail.
                mem_we    = 1'b1;
                mem_wdata = res_q;
                mem_addr  = mode_q ? tail_q : second_addr;
                head_d    = mode_q ? wrap_inc(wrap_inc(head_q)) : head_q;
                tail_d    = mode_q ? wrap_inc(tail_q) : tail_q;
                count_d   = count_q - 1'b1;
                dout_d    = res_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            op_q    <= OpPop;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            dout_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            dout_q  <= dout_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rdata_q <= mem[mem_addr];
    end

    assign dout  = dout_q;
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign busy  = (state_q != StIdle);
    assign err   = err_q;
    assign ovf   = ovf_q;

endmodule

// File: doc/stack_queue_alu.md
Name: stack_queue_alu

Overview:
- Parametrised successor to the current stack/queue adder memory: one buffer of DEPTH entries, each WIDTH bits wide.
- Operates as a LIFO stack or a FIFO queue.
- Adds pop, subtract, clear, operand-count checking, error and overflow flags, and a busy handshake.
- Sits between the debounced switch/button front end and the seven-segment display driver; dout feeds the display.

Parameters:
- WIDTH, 16, data width of each entry.
- DEPTH, 32, number of entries (need not be a power of two).
- CNT_W, $clog2(DEPTH+1), width of count.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stack_queue  in  1  mode request; 0 = stack, 1 = queue.
- din  in  WIDTH  data to push.
- push  in  1  single-cycle command: write din.
- pop  in  1  single-cycle command: remove one entry.
- op_add  in  1  single-cycle command: remove two entries, insert sum.
- op_sub  in  1  single-cycle command: remove two entries, insert difference.
- clear  in  1  single-cycle command: empty the buffer.
- dout  out  WIDTH  display register.
- count  out  CNT_W  number of valid entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- busy  out  1  FSM not in IDLE.
- err  out  1  one-cycle pulse on a rejected command.
- ovf  out  1  sticky arithmetic overflow/borrow flag.

Behaviour:
- Reset (rst=0, async): pointers, count, dout, ovf, err, busy = 0; mode = stack; FSM = IDLE. Memory contents are don't-care.
- Command acceptance: commands are sampled only in IDLE. Commands arriving while busy are silently ignored (no err).
- Priority among simultaneous commands: clear > push > pop > op_add > op_sub. Lower-priority commands in the same cycle are dropped.
- Mode register: loads stack_queue on every IDLE cycle with count == 0. Mode changes while data is present are ignored.
- Stack addressing: sp points to the next free slot; the top is sp-1.
- Queue addressing: head/tail pointers increment and wrap DEPTH-1 -> 0 by explicit compare.
- Memory: single-port, synchronous-read RAM.
- push (1 cycle): if full, no change and err=1 for one cycle. Otherwise din is written at the next edge, count+1, dout=din.
- pop: if empty, err. Otherwise a 2-cycle sequence IDLE -> RD_A -> IDLE: dout = removed value (stack top or queue head), count-1. busy=1 during RD_A.
- op_add / op_sub: if count < 2, err and no change. Otherwise a 4-cycle sequence with busy=1 throughout:
  - IDLE -> RD_A: first read; X = first removed entry (stack top / queue head).
  - RD_B: Y = second removed entry.
  - EXEC: result computed.
  - WR -> IDLE: result is pushed (stack) or enqueued at the tail (queue); count-1 net; dout = result.
- Arithmetic:
  - add result = Y + X; sub result = Y - X, computed at WIDTH+1 bits.
  - Stack example: push 5 then 3, sub -> 5 - 3 = 2.
  - Queue: Y - X means second-dequeued minus first-dequeued.
  - Carry-out (add) or borrow (sub) sets ovf. ovf is cleared only by reset or clear. The result is truncated to WIDTH bits.
- full/empty: an op started at full cannot overflow the buffer, because two entries are removed before one is written.
- clear (1 cycle): pointers and count = 0, ovf = 0, dout = 0.
- Reset asserted mid-operation aborts immediately to the reset state. No partial write survives as a valid entry.

Optional Feature:
- Macro: STACK_QUEUE_ALU_SAT_EN.
- Defined: on carry or borrow the result saturates to all-ones (add) or zero (sub); ovf is still set.
- Undefined: the result wraps modulo 2^WIDTH.

Test Plan:
- Stack fill: push 1..32 with WIDTH=16, DEPTH=32 -> full=1, count=32, dout=0x0020. 33rd push -> err pulse, count stays 32.
- Stack add chain: after the fill, 31 op_add -> first dout=0x003F; final dout=0x0210, count=1, busy high for 4 cycles each. A 32nd add -> err, dout unchanged.
- Queue ops, after reset with stack_queue=1: push 1,2,3,4; op_add -> dout=3, contents 3,4,3. Then op_sub (4-3) -> dout=1, contents 3,1.
- Queue wrap: alternate push k / pop for k=1..40 -> every pop's dout equals k; empty=1 at end; pointers pass index 31 with no error.
- Overflow: push 0xFFFF, 0x0002, op_add -> dout=0x0001, ovf=1 (SAT_EN: 0xFFFF). clear, then push 1, 5, op_sub -> dout=0xFFFC, ovf=1 (SAT_EN: 0x0000).
- Async reset: assert rst low during RD_B of an add -> dout, count, busy, ovf = 0 immediately; empty=1. The next push after release works normally.
